// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: FSM encoding and default sizing shared by the ROM sweep reader
package rom_ctrl_pkg;
    localparam int unsigned RomWidth       = 40;
    localparam int unsigned RomDigestWords = 2;
    localparam int unsigned DigestW        = RomWidth * RomDigestWords;
    // Linear (6,3) code: any two states differ in at least three bits
    typedef enum logic [5:0] {
        StIdle   = 6'b001011,
        StHash   = 6'b010101,
        StDigest = 6'b011110,
        StDone   = 6'b100110,
        StError  = 6'b101101
    } sweep_state_e;
endpackage

// File: rtl/prim_fifo_sync.sv
// prim_fifo_sync: small synchronous FIFO with registered storage and no pass-through
module prim_fifo_sync #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2,
    localparam int unsigned Pw = $clog2(Depth),
    localparam int unsigned Dw = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,
    output logic [Dw-1:0]    depth_o
);
    logic [Width-1:0] mem_q [Depth];
    logic [Pw-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [Dw-1:0] depth_q, depth_d;
    logic push, pop;
    assign wready_o = depth_q < Dw'(Depth);
    assign rvalid_o = depth_q != '0;
    assign rdata_o  = mem_q[rptr_q];
    assign depth_o  = depth_q;
    assign push     = wvalid_i && wready_o;
    assign pop      = rvalid_o && rready_i;
    always_comb begin
        wptr_d  = clr_i ? '0 : push ? (wptr_q == Pw'(Depth - 1) ? '0 : wptr_q + Pw'(1)) : wptr_q;
        rptr_d  = clr_i ? '0 : pop ? (rptr_q == Pw'(Depth - 1) ? '0 : rptr_q + Pw'(1)) : rptr_q;
        depth_d = clr_i ? '0 : depth_q + Dw'(push) - Dw'(pop);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            depth_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            depth_q <= depth_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/rom_ctrl_sweep_reader.sv
// rom_ctrl_sweep_reader: sweeps the ROM once, streams hash words and captures the expected digest
module rom_ctrl_sweep_reader
    import rom_ctrl_pkg::*;
#(
    parameter int unsigned Width       = RomWidth,
    parameter int unsigned Depth       = 16,
    parameter int unsigned DigestWords = RomDigestWords,
    localparam int unsigned Aw = $clog2(Depth)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic                         req_o,
    output logic [Aw-1:0]                rom_addr_o,
    output logic [Aw-1:0]                prince_addr_o,
    input  logic                         rvalid_i,
    input  logic [Width-1:0]             scr_rdata_i,
    input  logic [Width-1:0]             clr_rdata_i,
    output logic                         kmac_valid_o,
    output logic [Width-1:0]             kmac_data_o,
    output logic                         kmac_last_o,
    input  logic                         kmac_ready_i,
    output logic [DigestWords*Width-1:0] exp_digest_o,
    output logic                         done_o,
    output logic                         alert_o
);
    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);
    localparam logic [Aw-1:0] LastHash = Aw'(Depth - DigestWords - 1);
    sweep_state_e state_q, state_d;
    logic [Aw-1:0] rom_cnt_q, rom_cnt_d, prince_cnt_q, prince_cnt_d, rd_addr_q, rd_addr_d;
    logic outst_q, req_done_q, req_done_d, dig_done_q, dig_done_d;
    logic [DigestWords*Width-1:0] exp_q, exp_d;
    logic [Width:0] head;
    logic [1:0] fifo_depth;
    logic fifo_rvalid, fifo_wready, active, room, push, cap, cap_last, pop, fault;
    assign active   = state_q == StHash || state_q == StDigest;
    // Count the in-flight read so a stalled hash engine can never overflow the buffer
    assign room     = !(fifo_depth[1] || (fifo_depth[0] && outst_q));
    assign req_o    = active && !req_done_q && (rom_cnt_q > LastHash || room);
    assign push     = rvalid_i && outst_q && !alert_o && rd_addr_q <= LastHash;
    assign cap      = rvalid_i && outst_q && !alert_o && rd_addr_q > LastHash;
    assign cap_last = cap && rd_addr_q == LastAddr;
    assign pop      = kmac_valid_o && kmac_ready_i;
    assign fault    = rom_cnt_q != prince_cnt_q || (rvalid_i && !outst_q) || (push && !fifo_wready);
    assign rom_addr_o    = rom_cnt_q;
    assign prince_addr_o = prince_cnt_q;
    assign kmac_valid_o  = fifo_rvalid && !alert_o;
    assign kmac_data_o   = head[Width-1:0];
    assign kmac_last_o   = kmac_valid_o && head[Width];
    assign exp_digest_o  = alert_o ? '0 : exp_q;
    assign done_o        = state_q == StDone;
    assign alert_o       = state_q == StError;
    prim_fifo_sync #(.Width(Width + 1), .Depth(2)) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (alert_o),
        .wvalid_i (push),
        .wready_o (fifo_wready),
        .wdata_i  ({rd_addr_q == LastHash, scr_rdata_i}),
        .rvalid_o (fifo_rvalid),
        .rready_i (kmac_ready_i),
        .rdata_o  (head),
        .depth_o  (fifo_depth)
    );
    always_comb begin
        rom_cnt_d    = rom_cnt_q + Aw'(req_o && rom_cnt_q != LastAddr);
        prince_cnt_d = prince_cnt_q + Aw'(req_o && prince_cnt_q != LastAddr);
        rd_addr_d    = req_o ? rom_cnt_q : rd_addr_q;
        req_done_d   = req_done_q || (req_o && rom_cnt_q == LastAddr);
        dig_done_d   = dig_done_q || cap_last;
        exp_d        = exp_q;
        for (int k = 0; k < DigestWords; k++) begin
            if (cap && rd_addr_q == Aw'(Depth - DigestWords + k)) exp_d[k*Width +: Width] = clr_rdata_i;
        end
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = start_i ? StHash : StIdle;
            StHash:   state_d = (pop && head[Width]) ? StDigest : StHash;
            StDigest: state_d = (cap_last || dig_done_q) ? StDone : StDigest;
            StDone:   state_d = StDone;
            default:  state_d = StError;
        endcase
        if (fault) state_d = StError;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            rom_cnt_q    <= '0;
            prince_cnt_q <= '0;
            rd_addr_q    <= '0;
            outst_q      <= 1'b0;
            req_done_q   <= 1'b0;
            dig_done_q   <= 1'b0;
            exp_q        <= '0;
        end else begin
            state_q      <= state_d;
            rom_cnt_q    <= rom_cnt_d;
            prince_cnt_q <= prince_cnt_d;
            rd_addr_q    <= rd_addr_d;
            outst_q      <= req_o;
            req_done_q   <= req_done_d;
            dig_done_q   <= dig_done_d;
            exp_q        <= exp_d;
        end
    end
endmodule
